// File: rtl/data_memory_ext.sv
// data_memory_ext: word-organised data memory for the MEM stage.
// Byte/halfword/word loads and stores, one-cycle registered read data,
// an initialisation sequencer that clears the array and preloads the
// seven-segment table, and a fault pulse for misaligned or reserved-size
// requests.
module data_memory_ext #(
    parameter int RAM_SIZE_BIT = 5,
    parameter bit SEG_TABLE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        Read_valid,
    output logic        Busy,
    output logic        Fault
);

    localparam int RAM_SIZE = 2 ** RAM_SIZE_BIT;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t                  state;
    logic [RAM_SIZE_BIT-1:0] cnt;
    logic [31:0]             mem [RAM_SIZE];

    logic [RAM_SIZE_BIT-1:0] word_idx;
    logic [1:0]              lane;
    logic                    in_range;
    logic                    misaligned;
    logic                    bad_req;
    logic [31:0]             cur_word;
    logic [7:0]              byte_val;
    logic [15:0]             half_val;
    logic [31:0]             load_data;
    logic [3:0]              wmask;
    logic [31:0]             wdata;
    logic                    wr_en;

    // Preload value for one word: seven-segment code for hex 0..F, else zero
    function automatic logic [31:0] preload(input logic [RAM_SIZE_BIT-1:0] idx);
        logic [7:0] seg;
        case (idx[3:0])
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h6F;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            default: seg = 8'h71;
        endcase
        if (SEG_TABLE_EN && (32'(idx) < 32'd16)) begin
            return {24'h0, seg};
        end
        return '0;
    endfunction

    // Address decode, lane extraction for loads and lane mask for stores
    always_comb begin
        word_idx   = Address[RAM_SIZE_BIT+1:2];
        lane       = Address[1:0];
        in_range   = (Address >> (RAM_SIZE_BIT + 2)) == '0;
        misaligned = ((Size == 2'b01) && Address[0]) ||
                     ((Size == 2'b10) && (Address[1:0] != 2'b00));
        bad_req    = (MemRead || MemWrite) && (misaligned || (Size == 2'b11));
        cur_word   = mem[word_idx];
        byte_val   = 8'(cur_word >> {lane, 3'b000});
        half_val   = 16'(cur_word >> {lane[1], 4'b0000});
        load_data  = cur_word;
        wmask      = 4'b1111;
        wdata      = Write_data;
        case (Size)
            2'b00: begin
                load_data = Unsigned ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
                wmask     = 4'b0001 << lane;
                wdata     = {4{Write_data[7:0]}};
            end
            2'b01: begin
                load_data = Unsigned ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
                wmask     = 4'b0011 << {lane[1], 1'b0};
                wdata     = {2{Write_data[15:0]}};
            end
            default: begin
                load_data = cur_word;
                wmask     = 4'b1111;
                wdata     = Write_data;
            end
        endcase
        wr_en = (state == READY) && MemWrite && !bad_req && in_range;
    end

    // Array update: preload during INIT, lane-masked stores in READY.
    // The load path reads the array combinationally before this edge commits,
    // which gives read-before-write on a simultaneous read and write.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == INIT) begin
                mem[cnt] <= preload(cnt);
            end else if (wr_en) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (wmask[i]) begin
                        mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // Sequencer state, init counter and registered load/fault outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= INIT;
            cnt        <= '0;
            Read_data  <= '0;
            Read_valid <= 1'b0;
            Fault      <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    Read_valid <= 1'b0;
                    Fault      <= 1'b0;
                    cnt        <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state <= READY;
                    end
                end
                default: begin
                    Fault      <= bad_req;
                    Read_valid <= MemRead;
                    if (MemRead) begin
                        Read_data <= (bad_req || !in_range) ? '0 : load_data;
                    end
                end
            endcase
        end
    end

    assign Busy = (state == INIT);

endmodule

// File: tb/tb_data_memory_ext.sv
// tb_data_memory_ext: randomized and directed checks of data_memory_ext
// against a byte-addressed reference model of the memory.
module tb_data_memory_ext;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic        Read_valid;
    logic        Busy;
    logic        Fault;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: memory as a flat byte array, plus last load result
    logic [7:0]  ref_bytes [128];
    logic [31:0] last_data;

    data_memory_ext #(
        .RAM_SIZE_BIT(5),
        .SEG_TABLE_EN(1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Size      (Size),
        .Unsigned  (Unsigned),
        .Write_data(Write_data),
        .Read_data (Read_data),
        .Read_valid(Read_valid),
        .Busy      (Busy),
        .Fault     (Fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        logic [7:0] seg [16];
        seg = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
        for (int i = 0; i < 128; i++) ref_bytes[i] = 8'h00;
        for (int w = 0; w < 16; w++) ref_bytes[4*w] = seg[w];
        last_data = 32'h0;
    endtask

    task automatic idle();
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Size       = 2'b10;
        Unsigned   = 1'b0;
        Address    = 32'h0;
        Write_data = 32'h0;
    endtask

    // Hold reset for n edges; entered and left on a falling edge
    task automatic apply_reset(input int n);
        reset = 1'b0;
        idle();
        repeat (n) @(posedge clk);
        #1;
        check("rst_data", Read_data, 32'h0);
        check("rst_valid", Read_valid, 1'b0);
        check("rst_fault", Fault, 1'b0);
        check("rst_busy", Busy, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        model_init();
    endtask

    // Run init edges (at most limit) with random requests that must be ignored;
    // n returns the edge count up to and including the one where Busy dropped
    task automatic run_init(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            MemRead    = 1'($urandom);
            MemWrite   = 1'($urandom);
            Size       = 2'b10;
            Unsigned   = 1'b0;
            Address    = {25'h0, 5'($urandom), 2'b00};
            Write_data = $urandom;
            @(posedge clk);
            #1;
            n++;
            check("init_valid", Read_valid, 1'b0);
            check("init_fault", Fault, 1'b0);
            check("init_data", Read_data, last_data);
            @(negedge clk);
            idle();
            if (!Busy) break;
        end
    endtask

    // One READY request, checked against the reference model
    task automatic do_req(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd,
                          input string tag);
        logic        e_fault;
        logic        e_valid;
        logic [31:0] e_data;
        logic        inr;
        int          nb;
        @(negedge clk);
        check({tag, "_busy"}, Busy, 1'b0);
        MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns;
        Address = a; Write_data = wd;
        e_fault = (rd || wr) && ((sz == 2'b11) || (sz == 2'b01 && a[0]) ||
                                 (sz == 2'b10 && a[1:0] != 2'b00));
        inr     = (a < 32'd128);
        e_valid = rd;
        e_data  = last_data;
        nb      = 1 << sz;
        if (rd) begin
            e_data = 32'h0;
            if (!e_fault && inr) begin
                for (int k = 0; k < nb; k++) e_data = e_data | (32'(ref_bytes[a + k]) << (8 * k));
                if (!uns && nb < 4 && e_data[8*nb-1]) e_data = e_data | (32'hFFFF_FFFF << (8 * nb));
            end
        end
        if (wr && !e_fault && inr) begin
            for (int k = 0; k < nb; k++) ref_bytes[a + k] = 8'(wd >> (8 * k));
        end
        last_data = e_data;
        @(posedge clk);
        #1;
        check({tag, "_valid"}, Read_valid, e_valid);
        check({tag, "_fault"}, Fault, e_fault);
        check({tag, "_data"}, Read_data, e_data);
    endtask

    task automatic read_expect(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                               input logic [31:0] lit, input string tag);
        do_req(1'b1, 1'b0, sz, uns, a, 32'h0, tag);
        check({tag, "_lit"}, Read_data, lit);
    endtask

    task automatic readback_all();
        for (int w = 0; w < 32; w++) do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'(4 * w), 32'h0, "readback");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0]  sz;
        logic [31:0] a;
        apply_reset(3);
        run_init(100, n);
        check("init_len", 32'(n), 32'd32);

        read_expect(2'b10, 1'b0, 32'h00, 32'h0000_003F, "seg0");
        read_expect(2'b10, 1'b0, 32'h24, 32'h0000_006F, "seg9");
        read_expect(2'b10, 1'b0, 32'h3C, 32'h0000_0071, "segF");
        read_expect(2'b10, 1'b0, 32'h40, 32'h0000_0000, "zero16");

        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h1122_3344, "st_word");
        do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h41, 32'h0000_00AA, "st_byte");
        read_expect(2'b10, 1'b0, 32'h40, 32'h1122_AA44, "ld_word");
        read_expect(2'b00, 1'b0, 32'h41, 32'hFFFF_FFAA, "ld_sbyte");
        read_expect(2'b00, 1'b1, 32'h41, 32'h0000_00AA, "ld_ubyte");
        read_expect(2'b01, 1'b0, 32'h42, 32'h0000_1122, "ld_shalf");

        do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h41, 32'h0, "flt_half");
        do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, "flt_half_end");
        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h42, 32'hFFFF_FFFF, "flt_word");
        do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, "flt_word_end");
        do_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, "flt_size");
        do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, "flt_size_end");
        read_expect(2'b10, 1'b0, 32'h40, 32'h1122_AA44, "flt_keep");

        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h80, 32'hDEAD_BEEF, "oor_wr");
        read_expect(2'b10, 1'b0, 32'h80, 32'h0, "oor_rd");
        read_expect(2'b10, 1'b0, 32'h00, 32'h0000_003F, "oor_keep");

        do_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h44, 32'h5, "rbw");
        check("rbw_old", Read_data, 32'h0);
        read_expect(2'b10, 1'b0, 32'h44, 32'h5, "rbw_new");

        for (int i = 0; i < 400; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 'h9F));
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
            do_req(1'($urandom), 1'($urandom), sz, 1'($urandom), a, $urandom, "rnd");
        end
        readback_all();

        @(negedge clk);
        apply_reset(1);
        run_init(9, n);
        apply_reset(1);
        run_init(100, n);
        check("reinit_len", 32'(n), 32'd32);
        readback_all();

        @(negedge clk);
        apply_reset(2);
        run_init(100, n);
        check("ready_reset_len", 32'(n), 32'd32);
        readback_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
